// File: rtl/stream_demux_1to4.sv
// rtl/stream_demux_1to4.sv - 1:4 valid/ready stream demux with a 2-entry FIFO per lane
module stream_demux_1to4 #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   in_data,
   input  logic [1:0]     in_sel,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [4*N-1:0] out_data,
   output logic [3:0]     out_valid,
   input  logic [3:0]     out_ready,
   output logic           busy
);

   logic [N-1:0] mem [4][2];
   logic [1:0]   cnt [4];
   logic [3:0]   rd_ptr;
   logic [3:0]   wr_ptr;
   logic [3:0]   push;
   logic [3:0]   pop;

   // in_ready depends only on in_sel and lane counts, never on in_valid or out_ready
   always_comb begin
      in_ready  = (cnt[in_sel] != 2'd2);
      out_valid = '0;
      out_data  = '0;
      push      = '0;
      pop       = '0;
      for (int k = 0; k < 4; k++) begin
         out_valid[k]      = (cnt[k] != 2'd0);
         out_data[k*N +: N] = mem[k][rd_ptr[k]];
         push[k]           = in_valid && in_ready && (in_sel == 2'(k));
         pop[k]            = out_valid[k] && out_ready[k];
      end
   end

   assign busy = |out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int k = 0; k < 4; k++) begin
            cnt[k]    <= '0;
            mem[k][0] <= '0;
            mem[k][1] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
               mem[k][wr_ptr[k]] <= in_data;
               wr_ptr[k]         <= ~wr_ptr[k];
            end
            if (pop[k]) begin
               rd_ptr[k] <= ~rd_ptr[k];
            end
            // push and pop together leave the count unchanged
            case ({push[k], pop[k]})
               2'b10:   cnt[k] <= cnt[k] + 2'd1;
               2'b01:   cnt[k] <= cnt[k] - 2'd1;
               default: cnt[k] <= cnt[k];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// tb/tb_stream_demux_1to4.sv - scoreboard bench for stream_demux_1to4 with per-lane queue model
module tb_stream_demux_1to4;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_data;
   logic [1:0]     in_sel;
   logic           in_valid;
   logic           in_ready;
   logic [4*N-1:0] out_data;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready;
   logic           busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] mq [4][$];

   stream_demux_1to4 #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each lane is a queue of at most two words; accept decided on pre-edge occupancy
   always @(posedge clk) begin
      if (rst_n) begin
         bit acc;
         acc = in_valid && (mq[in_sel].size() < 2);
         for (int k = 0; k < 4; k++)
            if (out_ready[k] && mq[k].size() != 0) void'(mq[k].pop_front());
         if (acc) mq[in_sel].push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         bit any;
         any = 1'b0;
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0) begin
               any = 1'b1;
               chk($sformatf("out_data[%0d]", k), 32'(out_data[k*N +: N]), 32'(mq[k][0]));
            end
         end
         chk("in_ready", 32'(in_ready), 32'(mq[in_sel].size() < 2));
         chk("busy", 32'(busy), 32'(any));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [1:0] sel, input logic [N-1:0] d, output int stalls);
      bit ok;
      stalls   = 0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = d;
      ok       = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         if (!ok) stalls++;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      int st;
      logic [N-1:0] words [3];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_data   = '0;
      out_ready = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1 chk($sformatf("reset_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
      end
      cyc(1);

      // single lane back-to-back stream
      words[0] = 8'h03; words[1] = 8'h07; words[2] = 8'h0A;
      out_ready = 4'hF;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_sel   = 2'd1;
         in_data  = words[i];
         cyc(1);
      end
      in_valid = 1'b0;
      cyc(3);

      // fill lane 2 and check back-pressure is lane-local
      out_ready = 4'b1011;
      send(2'd2, 8'h05, st);
      send(2'd2, 8'h06, st);
      in_valid = 1'b1;
      in_sel   = 2'd2;
      in_data  = 8'h09;
      @(negedge clk);
      chk("full_lane2_in_ready", 32'(in_ready), 32'd0);
      in_sel = 2'd0;
      #1 chk("full_lane2_sel0_in_ready", 32'(in_ready), 32'd1);
      in_sel = 2'd2;
      @(posedge clk);
      #1;
      out_ready = 4'hF;
      send(2'd2, 8'h09, st);
      chk("free_lane_stalls", 32'(st), 32'd1);
      cyc(3);

      // simultaneous push and pop at count 1
      out_ready = 4'h0;
      send(2'd0, 8'h01, st);
      out_ready = 4'h1;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 8'h02;
      cyc(1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pushpop_valid", 32'(out_valid[0]), 32'd1);
      chk("pushpop_head", 32'(out_data[N-1:0]), 32'h02);
      cyc(1);
      @(negedge clk);
      chk("pushpop_drained", 32'(out_valid[0]), 32'd0);
      cyc(1);

      // asynchronous reset mid-stream
      out_ready = 4'h0;
      send(2'd0, 8'hA1, st);
      send(2'd2, 8'hB1, st);
      send(2'd2, 8'hB2, st);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_out_data", out_data, 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) mq[k].delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1 chk($sformatf("post_rst_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
      end
      cyc(1);

      // random traffic: first half with lane 3 stalled, second half unrestricted
      for (int i = 0; i < 10000; i++) begin
         int s;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = N'($urandom);
         if (i < 5000) begin
            s         = $urandom_range(0, 2);
            in_sel    = (s == 2) ? 2'd3 : 2'(s);
            out_ready = {2'b00, 2'($urandom_range(0, 3))};
         end else begin
            in_sel    = 2'($urandom_range(0, 3));
            out_ready = 4'($urandom_range(0, 15));
         end
         cyc(1);
      end

      in_valid  = 1'b0;
      out_ready = 4'hF;
      cyc(4);
      @(negedge clk);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
